fetch_unit: RTL and testbench

//  IF-stage producer for the IF/ID pipeline register. Drives instr_f/pc_f/pcplus4_f.
//  - Issues in-order word fetches to instruction memory over a valid/ready request channel.
//  - Buffers returned words in a small prefetch FIFO.
//  - Honours decode stall (hold) and branch/jump redirect (flush) from the hazard logic.

---
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: IF-stage fetcher with a credit-limited prefetch FIFO, decode stall and redirect flush.
// Optional feature macro FETCH_PERF_CNT_EN adds bubble_cnt, counting cycles decode sat idle.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] pcplus4_f
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] bubble_cnt
`endif
);
  localparam int          AW  = $clog2(DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP = 32'h00000013;

  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, inflight, discard;
  logic [31:0]   fetch_pc, rsp_pc, target;
  logic [CW:0]   outstanding;
  logic          req_fire, push, pop;

  assign target         = redirect_pc & 32'hFFFF_FFFC;
  assign outstanding    = {1'b0, inflight} + {1'b0, count};
  assign imem_req_valid = !reset && !redirect_valid && (outstanding < CAP);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && (discard == '0) && !redirect_valid;
  assign fetch_valid    = !reset && (count != '0);
  assign pop            = fetch_valid && !stall_d && !redirect_valid;

  assign instr_f   = fetch_valid ? fifo_data[rd_ptr] : NOP;
  assign pc_f      = fetch_valid ? fifo_pc[rd_ptr] : 32'h0;
  assign pcplus4_f = fetch_valid ? fifo_pc[rd_ptr] + 32'd4 : 32'h0;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]   <= rsp_pc;
    end
  end

  // A redirect marks every word still outstanding for discard, so discard never exceeds inflight.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= target;
      rsp_pc   <= target;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= inflight - CW'(imem_rsp_valid);
      discard  <= inflight - CW'(imem_rsp_valid);
    end else begin
      if (req_fire)
        fetch_pc <= fetch_pc + 32'd4;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rsp_pc <= rsp_pc + 32'd4;
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count    <= count + CW'(push) - CW'(pop);
      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (discard != '0))
        discard <= discard - CW'(1);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      bubble_cnt <= '0;
    else if (!fetch_valid && !stall_d)
      bubble_cnt <= bubble_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a queue-based reference model.
// A second instance with RESET_PC near the top of memory exercises address wrap.
module tb_fetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        stall_d, redirect_valid, fetch_valid;
  logic [31:0] redirect_pc, instr_f, pc_f, pcplus4_f;
  logic        req2_valid, rsp2_valid, fv2;
  logic [31:0] req2_addr, rsp2_data, instr2, pc2, p42;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_cnt, bubble2;
`endif

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall_d(stall_d), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid), .instr_f(instr_f), .pc_f(pc_f), .pcplus4_f(pcplus4_f)
`ifdef FETCH_PERF_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .reset(reset),
    .imem_req_valid(req2_valid), .imem_req_ready(1'b1), .imem_req_addr(req2_addr),
    .imem_rsp_valid(rsp2_valid), .imem_rsp_data(rsp2_data),
    .stall_d(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .fetch_valid(fv2), .instr_f(instr2), .pc_f(pc2), .pcplus4_f(p42)
`ifdef FETCH_PERF_CNT_EN
    , .bubble_cnt(bubble2)
`endif
  );

  typedef struct { logic [31:0] addr; bit stale; } out_t;
  typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  out_t        out_q[$];
  ent_t        fq[$];
  mreq_t       mem_q[$];
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_bubble = 32'h0;
  int          n_checks = 0, n_errors = 0, cyc = 0, lat_min = 1, lat_max = 1;
  bit          fire2_prev = 1'b0;
  logic [31:0] addr2_prev = 32'h0;
  int          got2 = 0;
  logic [31:0] cap2_pc[3], cap2_p4[3];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a ^ (a << 16)) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit exp_rv();
    return !reset && !redirect_valid && (out_q.size() + fq.size() < DEPTH);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string name);
    n_checks++;
    n_errors++;
    $display("[TB] FAIL %s: condition never reached within its cycle budget", name);
  endtask

  // Reference model: outstanding requests and buffered words as plain queues, updated each edge.
  always @(posedge clk) begin
    bit   fire, do_pop, push_new;
    out_t h;
    ent_t e;
    push_new = 1'b0;
    if (reset) begin
      out_q.delete();
      fq.delete();
      m_pc     = 32'h0;
      m_bubble = 32'h0;
    end else begin
      fire   = exp_rv() && imem_req_ready;
      do_pop = (fq.size() > 0) && !stall_d && !redirect_valid;
      if ((fq.size() == 0) && !stall_d)
        m_bubble = m_bubble + 32'd1;
      if (imem_rsp_valid) begin
        n_checks++;
        if (out_q.size() == 0) begin
          n_errors++;
          $display("[TB] FAIL rsp_without_inflight: got response with no outstanding request (cycle %0d)", cyc);
        end else begin
          h = out_q.pop_front();
          if (!redirect_valid && !h.stale) begin
            push_new = 1'b1;
            e = '{imem_rsp_data, h.addr};
          end
        end
      end
      if (redirect_valid) begin
        foreach (out_q[i]) out_q[i].stale = 1'b1;
        fq.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (do_pop) void'(fq.pop_front());
        if (push_new) fq.push_back(e);
        if (fire) begin
          out_q.push_back('{m_pc, 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic applyStimulus(input bit rst, input bit rdy, input bit stl, input bit rdr,
                               input logic [31:0] rpc);
    reset          = rst;
    imem_req_ready = rdy;
    stall_d        = stl;
    redirect_valid = rdr;
    redirect_pc    = rpc;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (rst) begin
      mem_q.delete();
    end else if ((mem_q.size() > 0) && (cyc >= mem_q[0].due)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memfn(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
    rsp2_valid = !rst && fire2_prev;
    rsp2_data  = memfn(addr2_prev);
  endtask

  task automatic checkOutput();
    bit          e_rv, e_fv;
    logic [31:0] e_instr, e_pc, e_p4;
    e_rv    = exp_rv();
    e_fv    = !reset && (fq.size() > 0);
    e_instr = e_fv ? fq[0].data : NOP;
    e_pc    = e_fv ? fq[0].pc : 32'h0;
    e_p4    = e_fv ? fq[0].pc + 32'd4 : 32'h0;
    cmp("req_valid", {31'b0, imem_req_valid}, {31'b0, e_rv});
    if (e_rv) cmp("req_addr", imem_req_addr, m_pc);
    cmp("fetch_valid", {31'b0, fetch_valid}, {31'b0, e_fv});
    cmp("instr_f", instr_f, e_instr);
    cmp("pc_f", pc_f, e_pc);
    cmp("pcplus4_f", pcplus4_f, e_p4);
`ifdef FETCH_PERF_CNT_EN
    if (cyc > 0) cmp("bubble_cnt", bubble_cnt, m_bubble);
`endif
  endtask

  task automatic step(input bit rst, input bit rdy, input bit stl, input bit rdr,
                      input logic [31:0] rpc);
    @(negedge clk);
    applyStimulus(rst, rdy, stl, rdr, rpc);
    #1;
    checkOutput();
    if (!rst && imem_req_valid && imem_req_ready)
      mem_q.push_back('{imem_req_addr, cyc + int'($urandom_range(lat_max, lat_min))});
    fire2_prev = !rst && req2_valid;
    addr2_prev = req2_addr;
    if (rst) got2 = 0;
    else if (fv2 && got2 < 3) begin
      cap2_pc[got2] = pc2;
      cap2_p4[got2] = p42;
      got2++;
    end
    cyc++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          k0, first_fv, got;
    bit          found;
    logic [31:0] seen[3];
    reset = 1'b1; imem_req_ready = 1'b0; stall_d = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    rsp2_valid = 1'b0; rsp2_data = 32'h0;

    // Idle memory after reset: every cycle is a bubble.
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    @(posedge clk); #1;
    cmp("bubble_cnt_after_10", bubble_cnt, 32'd10);
`endif

    // Streaming from reset with a 1-cycle memory.
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    k0 = cyc; first_fv = -1; got = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      if (i == 0) begin
        cmp("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        cmp("first_req_addr", imem_req_addr, 32'h0);
      end
      if (fetch_valid && first_fv < 0) first_fv = (cyc - 1) - k0;
      if (fetch_valid && got < 3) begin seen[got] = pc_f; got++; end
    end
    cmp("first_fetch_latency", first_fv, 32'd2);
    cmp("stream_pc0", seen[0], 32'h0);
    cmp("stream_pc1", seen[1], 32'h4);
    cmp("stream_pc2", seen[2], 32'h8);
    cmp("wrap_pc0", cap2_pc[0], 32'hFFFF_FFF8);
    cmp("wrap_pc1", cap2_pc[1], 32'hFFFF_FFFC);
    cmp("wrap_pc2", cap2_pc[2], 32'h0000_0000);
    cmp("wrap_pcplus4", cap2_p4[1], 32'h0);

    // Stall for five cycles with 0x10 at the head.
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      if (fetch_valid && pc_f == 32'hC) found = 1'b1;
    end
    if (!found) failNow("reach_pc_0xC");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      cmp("stall_hold_pc", pc_f, 32'h10);
      cmp("stall_hold_instr", instr_f, memfn(32'h10));
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cmp("release_pc", pc_f, 32'h10);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cmp("after_release_pc", pc_f, 32'h14);

    // Redirect to an unaligned target with a 3-cycle memory.
    lat_min = 3; lat_max = 3;
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h103);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cmp("redirect_bubble", {31'b0, fetch_valid}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (fetch_valid) found = 1'b1;
      else step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    if (!found) failNow("redirect_target_arrival");
    cmp("redirect_pc_f", pc_f, 32'h100);
    cmp("redirect_pcplus4_f", pcplus4_f, 32'h104);

    // Redirect beats a simultaneous stall.
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cmp("redirect_stall_bubble", {31'b0, fetch_valid}, 32'd0);
    cmp("redirect_stall_addr", imem_req_addr, 32'h200);

    // Randomized traffic: variable latency, backpressure, stalls, redirects, occasional reset.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(199, 0) == 0, $urandom_range(9, 0) < 7, $urandom_range(9, 0) < 3,
           $urandom_range(19, 0) == 0, $urandom);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
